mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter DEG_W, default 11, width of every degree field.
REQ-002 Parameter MAX_DEG_SUM, default 1512, largest legal dega+degb accepted for a product.
REQ-003 Parameter TIMEOUT, default 4096, watchdog limit in cycles (used only with MULT_ARB_TIMEOUT_EN).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  synchronous reset, active-low.
REQ-006 req0, req1  input  1 each  level request from requester 0 (inversion) / 1 (encaps), held until matching done.
REQ-007 dega0, degb0, dega1, degb1  input  DEG_W each  operand degrees from each requester, stable while req high.
REQ-008 gnt0, gnt1  output  1 each  requester owns the multiplier; one-hot or zero.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse to the owner.
REQ-010 err  output  1  valid only with a done pulse; 1 = request rejected or aborted.
REQ-011 mult_start  output  1  one-cycle start pulse to the shared polynomial multiplier.
REQ-012 mult_dega, mult_degb  output  DEG_W each  degrees routed from the granted requester.
REQ-013 mult_done  input  1  completion from the multiplier; sampled only in WAIT.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 States: IDLE, CHECK, START, WAIT, DONE; encoding free, unused codes return to IDLE.
REQ-016 IDLE: if any req high, latch winner into gnt and go CHECK; else stay.
REQ-017 Arbitration: round-robin; pointer names preferred requester, resets to 0, toggles to the non-winner on each DONE exit.
REQ-018 Simultaneous req0 and req1: preferred requester wins; single request wins regardless of pointer.
REQ-019 CHECK: dega+degb computed at DEG_W+1 bits; sum > MAX_DEG_SUM -> DONE with err=1, no mult_start; else START.
REQ-020 START: mult_start=1 for exactly one cycle, then WAIT.
REQ-021 WAIT: stay until mult_done=1, then DONE with err=0; mult_done outside WAIT is ignored.
REQ-022 DONE: pulse done of the owner (and err per outcome) for one cycle, clear gnt, go IDLE.
REQ-023 Latency: grant to mult_start = 2 cycles; mult_done to done pulse = 1 cycle; reject path grant to done = 2 cycles.
REQ-024 mult_dega/mult_degb mirror the granted requester's inputs combinationally; zero when no grant.
REQ-025 Requester dropping req while granted is not aborted; operation completes and done still pulses.
REQ-026 Back-to-back: a request held through DONE is re-arbitrated in IDLE the following cycle (minimum one IDLE cycle between grants).

Reset
REQ-027 rst_n=0 at a clock edge forces IDLE, pointer=0, and all outputs to 0 on the next cycle, including mid-WAIT.
REQ-028 Reset mid-operation produces no done pulse; the multiplier is not notified (owner re-requests).

Configuration
REQ-029 Macro MULT_ARB_TIMEOUT_EN defined: WAIT counter cleared at START, counts each WAIT cycle; reaching TIMEOUT -> DONE with err=1.
REQ-030 Macro MULT_ARB_TIMEOUT_EN undefined: no counter logic; WAIT is left only via mult_done or reset.

Verification
REQ-031 req0=1, dega0=756, degb0=756 -> gnt0 next cycle, mult_start 2 cycles after gnt0, mult_done -> done0=1, err=0 one cycle later.
REQ-032 req0=req1=1 from reset -> requester 0 served first, requester 1 granted after one IDLE cycle; repeated twice shows alternation.
REQ-033 req1=1, dega1=1000, degb1=600 -> no mult_start, done1=1 with err=1 two cycles after gnt1.
REQ-034 rst_n=0 while in WAIT -> next cycle busy=0, gnt=0, no done; later mult_done pulse ignored.
REQ-035 With MULT_ARB_TIMEOUT_EN, TIMEOUT=16, mult_done never asserted -> done0=1, err=1 at WAIT cycle 16; without macro, busy stays 1 for 100 cycles.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin arbiter granting two requesters (inversion / encapsulation) access to one
// polynomial multiplier. Defining MULT_ARB_TIMEOUT_EN adds a WAIT-state watchdog.
module mult_arbiter #(
    parameter int unsigned DEG_W       = 11,
    parameter int unsigned MAX_DEG_SUM = 1512,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [DEG_W-1:0] dega0,
    input  logic [DEG_W-1:0] degb0,
    input  logic [DEG_W-1:0] dega1,
    input  logic [DEG_W-1:0] degb1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             err,
    output logic             mult_start,
    output logic [DEG_W-1:0] mult_dega,
    output logic [DEG_W-1:0] mult_degb,
    input  logic             mult_done,
    output logic             busy
);

    localparam int unsigned SUM_W = DEG_W + 1;
    localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_DEG_SUM);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Reject a watchdog limit of zero at elaboration.
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mult_arbiter: TIMEOUT must be at least 1");
    end

    state_e state_q, state_d;
    logic   gnt0_q, gnt0_d;
    logic   gnt1_q, gnt1_d;
    logic   owner_q, owner_d;
    logic   ptr_q, ptr_d;
    logic   fail_q, fail_d;
    logic   done0_q, done0_d;
    logic   done1_q, done1_d;
    logic   err_q, err_d;
    logic   mult_start_q, mult_start_d;
    logic   busy_q, busy_d;

    logic             winner_c;
    logic [SUM_W-1:0] sum_c;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Operand routing follows the live grant; zero while nobody owns the multiplier.
    always_comb begin
        mult_dega = '0;
        mult_degb = '0;
        if (gnt0_q) begin
            mult_dega = dega0;
            mult_degb = degb0;
        end else if (gnt1_q) begin
            mult_dega = dega1;
            mult_degb = degb1;
        end
    end

    // One extra bit so the degree sum can never wrap before the limit check.
    assign sum_c    = SUM_W'(mult_dega) + SUM_W'(mult_degb);
    assign winner_c = (req0 && req1) ? ptr_q : req1;

    always_comb begin
        state_d      = state_q;
        gnt0_d       = gnt0_q;
        gnt1_d       = gnt1_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        fail_d       = fail_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err_d        = 1'b0;
        mult_start_d = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = winner_c;
                    gnt0_d  = ~winner_c;
                    gnt1_d  = winner_c;
                    fail_d  = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (sum_c > MAX_SUM) begin
                    fail_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = START;
                end
            end
            START: begin
                mult_start_d = 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
                cnt_d        = '0;
`endif
                state_d      = WAIT;
            end
            WAIT: begin
                if (mult_done) begin
                    fail_d  = 1'b0;
                    state_d = DONE;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    fail_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                done0_d = ~owner_q;
                done1_d = owner_q;
                err_d   = fail_q;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                ptr_d   = ~owner_q;
                state_d = IDLE;
            end
            default: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            owner_q      <= 1'b0;
            ptr_q        <= 1'b0;
            fail_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err_q        <= 1'b0;
            mult_start_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            fail_q       <= fail_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err_q        <= err_d;
            mult_start_q <= mult_start_d;
            busy_q       <= busy_d;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign err        = err_q;
    assign mult_start = mult_start_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: event-timeline reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mult_arbiter;

    localparam int unsigned DEG_W   = 11;
    localparam int          MAX_SUM = 1512;
    localparam int          TMO     = 16;
`ifdef MULT_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             req0, req1;
    logic [DEG_W-1:0] dega0, degb0, dega1, degb1;
    logic             gnt0, gnt1, done0, done1, err, mult_start, mult_done, busy;
    logic [DEG_W-1:0] mult_dega, mult_degb;

    mult_arbiter #(.DEG_W(DEG_W), .MAX_DEG_SUM(MAX_SUM), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .dega0(dega0), .degb0(degb0), .dega1(dega1), .degb1(degb1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .mult_start(mult_start), .mult_dega(mult_dega), .mult_degb(mult_degb),
        .mult_done(mult_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the owner and the number of edges since its grant.
    int m_own   = -1;
    int m_age   = 0;
    int m_wcnt  = 0;
    bit m_rej   = 0;
    bit m_fin   = 0;
    bit m_ferr  = 0;
    bit m_ptr   = 0;
    bit m_valid = 0;
    bit e_done0 = 0, e_done1 = 0, e_err = 0, e_start = 0;

    function automatic int own_sum();
        if (m_own == 1) return int'(dega1) + int'(degb1);
        return int'(dega0) + int'(degb0);
    endfunction

    task automatic finish_op(input bit with_err);
        if (m_own == 0) e_done0 = 1'b1;
        else e_done1 = 1'b1;
        e_err = with_err;
        m_ptr = (m_own == 0);
        m_own = -1;
    endtask

    always @(posedge clk) begin
        e_done0 = 0; e_done1 = 0; e_err = 0; e_start = 0;
        if (!rst_n) begin
            m_own = -1; m_ptr = 0; m_valid = 1;
        end else if (m_own < 0) begin
            if (req0 && req1) m_own = int'(m_ptr);
            else if (req0) m_own = 0;
            else if (req1) m_own = 1;
            m_age = 0; m_fin = 0; m_wcnt = 0;
        end else if (m_age == 0) begin
            m_rej = own_sum() > MAX_SUM;
            m_age = 1;
        end else if (m_age == 1) begin
            if (m_rej) finish_op(1'b1);
            else begin e_start = 1; m_age = 2; end
        end else if (m_fin) begin
            finish_op(m_ferr);
        end else if (mult_done) begin
            m_fin = 1; m_ferr = 0;
        end else begin
            m_wcnt++;
            if (TO_EN && m_wcnt == TMO) begin m_fin = 1; m_ferr = 1; end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("gnt0", 32'(gnt0), 32'(m_own == 0));
            chk("gnt1", 32'(gnt1), 32'(m_own == 1));
            chk("busy", 32'(busy), 32'(m_own >= 0));
            chk("mult_start", 32'(mult_start), 32'(e_start));
            chk("done0", 32'(done0), 32'(e_done0));
            chk("done1", 32'(done1), 32'(e_done1));
            if (e_done0 || e_done1 || done0 || done1) chk("err", 32'(err), 32'(e_err));
            chk("mult_dega", 32'(mult_dega),
                m_own == 0 ? 32'(dega0) : (m_own == 1 ? 32'(dega1) : 32'd0));
            chk("mult_degb", 32'(mult_degb),
                m_own == 0 ? 32'(degb0) : (m_own == 1 ? 32'(degb1) : 32'd0));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return mult_start;
            1:       return done0;
            2:       return done1;
            default: return done0 | done1;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string nm);
        int n = 0;
        while (!probe(sel) && n < 300) begin
            step(1);
            n++;
        end
        chk(nm, 32'(probe(sel)), 32'd1);
    endtask

    // Over-limit request: granted, never started, done with err two cycles after grant.
    task automatic reject_op(input bit who, input int a, input int b, input string nm);
        if (who) begin dega1 = DEG_W'(a); degb1 = DEG_W'(b); req1 = 1; end
        else begin dega0 = DEG_W'(a); degb0 = DEG_W'(b); req0 = 1; end
        step(1);
        chk({nm, "_gnt"}, 32'(who ? gnt1 : gnt0), 32'd1);
        step(2);
        chk({nm, "_done"}, 32'(who ? done1 : done0), 32'd1);
        chk({nm, "_err"}, 32'(err), 32'd1);
        req0 = 0; req1 = 0;
    endtask

    initial begin
        int n;
        rst_n = 0; req0 = 0; req1 = 0; mult_done = 0;
        dega0 = '0; degb0 = '0; dega1 = '0; degb1 = '0;
        step(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        rst_n = 1;
        step(1);

        // Accepted at the exact degree-sum limit 756+756=1512.
        dega0 = 11'd756; degb0 = 11'd756; req0 = 1;
        step(1);
        chk("acc_gnt0", 32'(gnt0), 32'd1);
        chk("acc_dega", 32'(mult_dega), 32'd756);
        step(1);
        chk("acc_start_early", 32'(mult_start), 32'd0);
        step(1);
        chk("acc_start", 32'(mult_start), 32'd1);
        step(3);
        mult_done = 1;
        step(1);
        mult_done = 0;
        chk("acc_done_early", 32'(done0), 32'd0);
        step(1);
        chk("acc_done0", 32'(done0), 32'd1);
        chk("acc_err", 32'(err), 32'd0);
        req0 = 0;

        reject_op(1'b1, 1000, 600, "rej1600");
        reject_op(1'b0, 757, 756, "rej1513");
        reject_op(1'b1, 2047, 2047, "rej4094");

        // mult_done while idle / checking is ignored; requester drops req mid-WAIT.
        dega0 = 11'd10; degb0 = 11'd20; req0 = 1; mult_done = 1;
        step(2);
        mult_done = 0;
        step(1);
        chk("early_done_start", 32'(mult_start), 32'd1);
        step(2);
        chk("early_done_busy", 32'(busy), 32'd1);
        req0 = 0;
        step(1);
        mult_done = 1;
        step(1);
        mult_done = 0;
        step(1);
        chk("drop_done0", 32'(done0), 32'd1);

        // Both requesting from reset: strict alternation 0,1,0,1.
        rst_n = 0;
        step(1);
        rst_n = 1;
        dega0 = 11'd100; degb0 = 11'd200; dega1 = 11'd300; degb1 = 11'd400;
        req0 = 1; req1 = 1;
        for (int i = 0; i < 4; i++) begin
            wait_for(0, "rr_start");
            chk("rr_owner", 32'(gnt0), 32'((i % 2) == 0));
            mult_done = 1;
            step(1);
            mult_done = 0;
            wait_for(3, "rr_done");
            chk("rr_done0", 32'(done0), 32'((i % 2) == 0));
            if (i == 3) begin req0 = 0; req1 = 0; end
        end

        // Leave the pointer at 1, then reset mid-WAIT.
        reject_op(1'b0, 2047, 2047, "rej_ptr");
        dega1 = 11'd5; degb1 = 11'd5; req1 = 1;
        wait_for(0, "rw_start");
        step(2);
        rst_n = 0;
        step(1);
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_gnt1", 32'(gnt1), 32'd0);
        chk("rw_done1", 32'(done1), 32'd0);
        rst_n = 1; req1 = 0;
        step(1);
        mult_done = 1;
        step(1);
        mult_done = 0;
        step(3);
        chk("rw_late_done1", 32'(done1), 32'd0);

        // Pointer was cleared by reset: requester 0 wins the tie.
        dega0 = 11'd10; degb0 = 11'd20; req0 = 1; req1 = 1;
        step(1);
        chk("ptr_reset_gnt0", 32'(gnt0), 32'd1);
        req1 = 0;
        wait_for(0, "to_start");
`ifdef MULT_ARB_TIMEOUT_EN
        n = 0;
        while (!done0 && n < 40) begin
            step(1);
            n++;
        end
        chk("to_cycles", 32'(n), 32'd17);
        chk("to_done0", 32'(done0), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        req0 = 0;
`else
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (busy) n++;
        end
        chk("nto_busy_cycles", 32'(n), 32'd100);
        rst_n = 0; req0 = 0;
        step(1);
        rst_n = 1;
`endif
        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
